// File: rtl/snes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : snes_pad_reader
// Description : Polls two SNES-style serial controllers at a fixed rate and
//               presents each pad's 16 button bits as a parallel word.
//               Generates the shared latch/clock strobes, synchronises the
//               asynchronous serial data lines and publishes both words
//               together with a one-cycle valid pulse at the end of a poll.
// Ports       : clock         - system clock
//               reset         - synchronous reset, active-high
//               pad_data[1:0] - serial data from pad 1 [0] / pad 2 [1],
//                               active-low, asynchronous
//               pad_latch     - latch strobe to both pads
//               pad_clk       - shift clock to both pads, idles high
//               p1_buttons    - pad 1 buttons, 1 = pressed, bit i = slot i
//               p2_buttons    - pad 2 buttons, same encoding
//               pads_present  - [n] set when pad n+1 read bits 15:12 released
//               buttons_valid - one-cycle pulse when the words update
// Revision    : 1.0 - initial release
// ============================================================================
module snes_pad_reader #(
    parameter int HALF_PERIOD  = 300,
    parameter int IDLE_PERIODS = 1333
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] p1_buttons,
    output logic [15:0] p2_buttons,
    output logic [1:0]  pads_present,
    output logic        buttons_valid
);

    localparam int c_BIT_CYC  = 2 * HALF_PERIOD;
    localparam int c_IDLE_CYC = IDLE_PERIODS * c_BIT_CYC;
    localparam int c_CNT_MAX  = (c_IDLE_CYC > c_BIT_CYC) ? c_IDLE_CYC : c_BIT_CYC;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_IDLE_LAST = c_CNT_W'(c_IDLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LOW_LAST  = c_CNT_W'(HALF_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(HALF_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_slot;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [15:0]        r_shift_p1;
    logic [15:0]        r_shift_p2;
    logic               r_pad_latch;
    logic               r_pad_clk;
    logic [15:0]        r_p1_buttons;
    logic [15:0]        r_p2_buttons;
    logic [1:0]         r_pads_present;
    logic               r_buttons_valid;

    state_t             w_next_state;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic [3:0]         w_next_slot;
    logic               w_capture;
    logic               w_publish;
    logic               w_next_latch;
    logic               w_next_pad_clk;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 1'b1;
        w_next_slot  = r_slot;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cnt == c_IDLE_LAST) begin
                    w_next_state = S_LATCH;
                    w_next_cnt   = '0;
                end
            end
            S_LATCH: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_next_state = S_SHIFT;
                    w_next_cnt   = '0;
                    w_next_slot  = 4'd0;
                end
            end
            S_SHIFT: begin
                // Sample at the end of the low phase; the pad only moves to
                // the next bit on the following rising edge of pad_clk.
                w_capture = (r_cnt == c_LOW_LAST);
                if (r_cnt == c_BIT_LAST) begin
                    w_next_cnt = '0;
                    if (r_slot == 4'd15) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_slot = r_slot + 4'd1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase

        // Outputs are decoded from the next state so that they are flops
        // aligned with the state they describe.
        w_publish      = (w_next_state == S_DONE);
        w_next_latch   = (w_next_state == S_LATCH);
        w_next_pad_clk = !((w_next_state == S_SHIFT) && (w_next_cnt < c_HALF));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_slot          <= 4'd0;
            r_sync1         <= 2'b11;
            r_sync2         <= 2'b11;
            r_shift_p1      <= 16'h0000;
            r_shift_p2      <= 16'h0000;
            r_pad_latch     <= 1'b0;
            r_pad_clk       <= 1'b1;
            r_p1_buttons    <= 16'h0000;
            r_p2_buttons    <= 16'h0000;
            r_pads_present  <= 2'b00;
            r_buttons_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_slot      <= w_next_slot;
            r_sync1     <= pad_data;
            r_sync2     <= r_sync1;
            r_pad_latch <= w_next_latch;
            r_pad_clk   <= w_next_pad_clk;
            if (w_capture) begin
                r_shift_p1[r_slot] <= ~r_sync2[0];
                r_shift_p2[r_slot] <= ~r_sync2[1];
            end
            if (w_publish) begin
                r_p1_buttons   <= r_shift_p1;
                r_p2_buttons   <= r_shift_p2;
                // A real pad always returns the four unused slots released;
                // a floating/pulled-low line reads them as pressed.
                r_pads_present <= {(r_shift_p2[15:12] == 4'b0000),
                                   (r_shift_p1[15:12] == 4'b0000)};
            end
            r_buttons_valid <= w_publish;
        end
    end

    assign pad_latch     = r_pad_latch;
    assign pad_clk       = r_pad_clk;
    assign p1_buttons    = r_p1_buttons;
    assign p2_buttons    = r_p2_buttons;
    assign pads_present  = r_pads_present;
    assign buttons_valid = r_buttons_valid;

endmodule
`default_nettype wire
